// File: rtl/cmd_deserializer_frontend.sv
// cmd_deserializer_frontend: 8N1 serial receiver that packs four bytes into one
// big-endian 32-bit command word. It flags stop-bit framing errors and
// inter-byte timeouts, and each of these is reported as a one-cycle strobe.
module cmd_deserializer_frontend #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_CNT_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BIT_CNT_W-1:0] HALF_LOAD = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_LOAD = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LIMIT  = TO_CNT_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic                  rx_prev_q, rx_prev_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           word_q, word_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  start_edge;

    // A start edge only counts once the synchronizer carries a real line sample
    // that has been seen high; a line that is held low through reset release
    // therefore never starts a frame.
    assign start_edge = (state_q == IDLE) && armed_q && rx_prev_q && !rx_s_q;

    // Next-state logic for the synchronizer, frame FSM, word assembly and timeout.
    always_comb begin
        state_d       = state_q;
        sync1_d       = rx;
        rx_s_d        = sync1_q;
        rx_prev_d     = rx_s_q;
        settle_d      = {settle_q[0], 1'b1};
        armed_d       = armed_q | (settle_q[1] & rx_s_q);
        bit_cnt_d     = bit_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        to_cnt_d      = to_cnt_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = START;
                    bit_cnt_d = HALF_LOAD;
                    to_cnt_d  = '0;
                end else if (byte_idx_q != 2'd0) begin
                    if (to_cnt_q == TO_LIMIT) begin
                        timeout_err_d = 1'b1;
                        byte_idx_d    = 2'd0;
                        to_cnt_d      = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                    end
                end
            end
            START: begin
                if (bit_cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_cnt_d = FULL_LOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt_q == '0) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        case (byte_idx_q)
                            2'd0:    word_d[23:16] = shift_q;
                            2'd1:    word_d[15:8]  = shift_q;
                            2'd2:    word_d[7:0]   = shift_q;
                            default: begin
                                data_out_d = {word_q, shift_q};
                                valid_d    = 1'b1;
                            end
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = 2'd0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any partial byte or word immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            settle_q      <= 2'b00;
            armed_q       <= 1'b0;
            bit_cnt_q     <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            byte_idx_q    <= 2'd0;
            word_q        <= 24'h0;
            to_cnt_q      <= '0;
            data_out_q    <= 32'h0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            to_cnt_q      <= to_cnt_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule
